fetch_queue: RTL and testbench

//  Parametrised decoupled instruction-fetch buffer for the pipelined RISC-V core.

---
 rtl/fetch_queue_if.sv | 48 ++++
 rtl/fetch_queue.sv | 93 +++++++++
 tb/tb_fetch_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: imem fetch port, redirect request and the Decode-side head handshake.
// The queue takes the master view; imem/Decode/redirect source take the slave view.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  instr_pc;
    logic [XLEN-1:0]  instr_pc4;
    logic [CNT_W-1:0] count;
    logic             full;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output instr_pc4,
        output count,
        output full
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  instr_pc4,
        input  count,
        input  full
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch buffer: owns the fetch PC, prefetches one word per cycle
// into a DEPTH-entry first-word-fall-through FIFO, and flushes/redirects on a taken branch.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam int              CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN    = {{(XLEN-2){1'b1}}, 2'b00};

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  pc_q, pc_d;

    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic head_valid;
    logic full;
    logic deq;
    logic enq;

    assign head_valid = (count_q != '0);
    assign full       = (count_q == FULL_CNT);
    assign deq        = head_valid & bus.instr_ready;
    // A full queue may still accept the new word when the head leaves in the same cycle.
    assign enq        = ~bus.redirect & (~full | deq);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = bus.redirect_pc & ALIGN;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + PC_STEP;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= RESET_PC;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

    // Payload storage is not reset; the head is only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
    assign bus.instr_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.instr_pc4   = head_valid ? (pc_mem_q[rd_ptr_q] + PC_STEP) : '0;
    assign bus.count       = count_q;
    assign bus.full        = full;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; imem returns the bitwise inverse of the address.
`timescale 1ns/1ps
module tb_fetch_queue;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   n54;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_rdata = ~bus.imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.instr_valid && bus.instr_ready && bus.instr_pc == 32'h54) n54++;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        #3;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full got=%0b exp=0", bus.full); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL rst_nop got=%h exp=00000013", bus.instr); end
        step();
        step();
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_hold_addr got=%h exp=0", bus.imem_addr); end
        reset = 1'b1;
        step();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b exp=1", bus.instr_valid); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL first_count got=%0d exp=1", bus.count); end
        checks++; if (bus.instr !== ~32'h0) begin errors++; $display("FAIL first_instr got=%h exp=ffffffff", bus.instr); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", bus.count); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("FAIL fill_addr got=%h exp=10", bus.imem_addr); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL fill_head_pc got=%h exp=0", bus.instr_pc); end
        checks++; if (bus.instr_pc4 !== 32'h4) begin errors++; $display("FAIL fill_head_pc4 got=%h exp=4", bus.instr_pc4); end
    endtask

    task automatic test_full_deq;
        logic [31:0] exp;
        exp = 32'h0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.instr_pc !== exp) begin errors++; $display("FAIL fdeq_pc[%0d] got=%h exp=%h", i, bus.instr_pc, exp); end
            checks++; if (bus.instr !== ~exp) begin errors++; $display("FAIL fdeq_instr[%0d] got=%h exp=%h", i, bus.instr, ~exp); end
            checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fdeq_count[%0d] got=%0d exp=4", i, bus.count); end
            step();
            exp = exp + 32'h4;
        end
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_pc !== 32'h20) begin errors++; $display("FAIL fdeq_end_pc got=%h exp=20", bus.instr_pc); end
        checks++; if (bus.imem_addr !== 32'h30) begin errors++; $display("FAIL fdeq_end_addr got=%h exp=30", bus.imem_addr); end
    endtask

    task automatic test_redirect;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h43;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL redir_count got=%0d exp=0", bus.count); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got=%h exp=40", bus.imem_addr); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL redir_full got=%0b exp=0", bus.full); end
        checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL redir_nop got=%h exp=00000013", bus.instr); end
        checks++; if (bus.instr_pc !== 32'h0 || bus.instr_pc4 !== 32'h0) begin errors++; $display("FAIL redir_empty_pc got=%h/%h exp=0/0", bus.instr_pc, bus.instr_pc4); end
        step();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL redir2_valid got=%0b exp=1", bus.instr_valid); end
        checks++; if (bus.instr_pc !== 32'h40) begin errors++; $display("FAIL redir2_pc got=%h exp=40", bus.instr_pc); end
        checks++; if (bus.instr_pc4 !== 32'h44) begin errors++; $display("FAIL redir2_pc4 got=%h exp=44", bus.instr_pc4); end
        checks++; if (bus.instr !== ~32'h40) begin errors++; $display("FAIL redir2_instr got=%h exp=%h", bus.instr, ~32'h40); end
    endtask

    task automatic test_stream;
        logic [31:0] exp;
        exp = 32'h40;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, bus.instr_valid); end
            checks++; if (bus.instr_pc !== exp) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.instr_pc, exp); end
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, bus.count); end
            step();
            exp = exp + 32'h4;
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_redirect_deq;
        step();
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL rdq_pre_count got=%0d exp=2", bus.count); end
        checks++; if (bus.instr_pc !== 32'h54) begin errors++; $display("FAIL rdq_pre_pc got=%h exp=54", bus.instr_pc); end
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rdq_count got=%0d exp=0", bus.count); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rdq_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rdq_addr got=%h exp=200", bus.imem_addr); end
        step();
        checks++; if (bus.instr_pc !== 32'h200) begin errors++; $display("FAIL rdq_new_pc got=%h exp=200", bus.instr_pc); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL rdq_new_count got=%0d exp=1", bus.count); end
        step();
        checks++; if (bus.instr_pc !== 32'h204) begin errors++; $display("FAIL rdq_next_pc got=%h exp=204", bus.instr_pc); end
        checks++; if (n54 !== 1) begin errors++; $display("FAIL rdq_head_once got=%0d exp=1", n54); end
    endtask

    task automatic test_redirect_hold;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL hold1_count got=%0d exp=0", bus.count); end
        checks++; if (bus.imem_addr !== 32'h300) begin errors++; $display("FAIL hold1_addr got=%h exp=300", bus.imem_addr); end
        bus.redirect_pc = 32'h311;
        step();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL hold2_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h310) begin errors++; $display("FAIL hold2_addr got=%h exp=310", bus.imem_addr); end
        bus.redirect = 1'b0;
        step();
        checks++; if (bus.instr_pc !== 32'h310) begin errors++; $display("FAIL hold3_pc got=%h exp=310", bus.instr_pc); end
        checks++; if (bus.imem_addr !== 32'h314) begin errors++; $display("FAIL hold3_addr got=%h exp=314", bus.imem_addr); end
    endtask

    task automatic test_reset_mid;
        step();
        step();
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", bus.count); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%0b exp=0", bus.instr_valid); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL mid_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", bus.count); end
        checks++; if (bus.instr !== 32'h13) begin errors++; $display("FAIL mid_nop got=%h exp=00000013", bus.instr); end
        step();
        reset = 1'b1;
        step();
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin errors++; $display("FAIL mid_restart got=%0b/%h exp=1/0", bus.instr_valid, bus.instr_pc); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL mid_restart_count got=%0d exp=1", bus.count); end
        bus.instr_ready = 1'b1;
        step();
        checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("FAIL mid_next_pc got=%h exp=4", bus.instr_pc); end
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL mid_next_count got=%0d exp=1", bus.count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n54 = 0;
        test_reset();
        test_full_deq();
        test_redirect();
        test_stream();
        test_redirect_deq();
        test_redirect_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
